// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared constants and helpers for the NoC root endpoint
package common_pkg;

  localparam int ROOT_EP_CNT_W = 32;

  // Index of the highest set bit; callers pass one-hot vectors.
  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_root_endpoint_if.sv
// rtl/noc_root_endpoint_if.sv - flit/credit bundle between the network and a root endpoint
interface noc_root_endpoint_if #(
  parameter int VC_W  = 2,
  parameter int PKT_W = 35
);
  logic [VC_W-1:0]  rx_vc_target;
  logic [PKT_W-1:0] rx_packet;
  logic [VC_W-1:0]  rx_vc_credit_gnt;
  logic [VC_W-1:0]  tx_vc_target;
  logic [PKT_W-1:0] tx_packet;
  logic [VC_W-1:0]  tx_vc_credit_gnt;

  modport master (
    output rx_vc_target, rx_packet, tx_vc_credit_gnt,
    input  rx_vc_credit_gnt, tx_vc_target, tx_packet
  );

  modport slave (
    input  rx_vc_target, rx_packet, tx_vc_credit_gnt,
    output rx_vc_credit_gnt, tx_vc_target, tx_packet
  );
endinterface

// File: rtl/noc_vc_fifo.sv
// rtl/noc_vc_fifo.sv - per-VC flit buffer; push and pop may coincide even when full
module noc_vc_fifo #(
  parameter int PKT_W = 35,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PKT_W-1:0] din,
  input  logic             pop,
  output logic [PKT_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = bump(wr_ptr_q);
    end
    if (pop) rd_ptr_d = bump(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the cleared count makes old entries unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/noc_root_endpoint.sv
// rtl/noc_root_endpoint.sv - root port: per-VC buffering, credit-gated round-robin send
// Optional flit counters rx_count/tx_count with NOC_ROOT_ENDPOINT_STATS_EN.
module noc_root_endpoint
  import common_pkg::*;
#(
  parameter int N             = 4,
  parameter int VC_W          = 2,
  parameter int D_W           = 32,
  parameter int A_W           = $clog2(N) + 1,
  parameter int VC_FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  noc_root_endpoint_if.slave       nif,
  output logic                     err
`ifdef NOC_ROOT_ENDPOINT_STATS_EN
  ,
  output logic [ROOT_EP_CNT_W-1:0] rx_count,
  output logic [ROOT_EP_CNT_W-1:0] tx_count
`endif
);
  localparam int PKT_W = A_W + D_W;
  localparam int CW    = $clog2(VC_FIFO_DEPTH + 1);
  localparam int PW    = (VC_W > 1) ? $clog2(VC_W) : 1;

  logic [VC_W-1:0]  fifo_push, fifo_full, fifo_empty, elig, gnt;
  logic [PKT_W-1:0] fifo_dout [VC_W];
  logic [PKT_W-1:0] sel_pkt;
  logic [CW-1:0]    cred_q [VC_W];
  logic [CW-1:0]    cred_d [VC_W];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             overflow, overrun, found;
  int               gnt_idx;

  logic [VC_W-1:0]  tx_vc_target_q, tx_vc_target_d;
  logic [VC_W-1:0]  rx_vc_credit_gnt_q, rx_vc_credit_gnt_d;
  logic [PKT_W-1:0] tx_packet_q, tx_packet_d;
  logic             err_q, err_d;

  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    noc_vc_fifo #(.PKT_W(PKT_W), .DEPTH(VC_FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[v]),
      .din   (nif.rx_packet),
      .pop   (gnt[v]),
      .dout  (fifo_dout[v]),
      .full  (fifo_full[v]),
      .empty (fifo_empty[v])
    );
  end

  // Eligibility looks only at registered state, so an arriving flit cannot bypass.
  always_comb begin
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = !fifo_empty[v] && (cred_q[v] != '0);
    end
  end

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < VC_W; i++) begin
      for (int j = 0; j < VC_W; j++) begin
        if (!found && elig[j] && (((int'(ptr_q) + i) % VC_W) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_pkt = '0;
    for (int v = 0; v < VC_W; v++) begin
      if (gnt[v]) sel_pkt = fifo_dout[v];
    end
    gnt_idx = onehot_to_idx(32'(gnt));
    ptr_d   = ptr_q;
    if (|gnt) ptr_d = (gnt_idx == VC_W - 1) ? '0 : PW'(gnt_idx + 1);
  end

  // A full FIFO still accepts when its head leaves in the same cycle.
  always_comb begin
    fifo_push = '0;
    overflow  = 1'b0;
    for (int v = 0; v < VC_W; v++) begin
      if (nif.rx_vc_target[v]) begin
        if (!fifo_full[v] || gnt[v]) fifo_push[v] = 1'b1;
        else                         overflow     = 1'b1;
      end
    end
  end

  always_comb begin
    overrun = 1'b0;
    for (int v = 0; v < VC_W; v++) begin
      cred_d[v] = cred_q[v];
      if (gnt[v] && !nif.tx_vc_credit_gnt[v]) begin
        cred_d[v] = cred_q[v] - 1'b1;
      end else if (!gnt[v] && nif.tx_vc_credit_gnt[v]) begin
        if (cred_q[v] == CW'(VC_FIFO_DEPTH)) overrun   = 1'b1;
        else                                 cred_d[v] = cred_q[v] + 1'b1;
      end
    end
  end

  always_comb begin
    tx_vc_target_d     = gnt;
    rx_vc_credit_gnt_d = gnt;
    tx_packet_d        = sel_pkt;
    err_d              = err_q | overflow | overrun;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_W; v++) cred_q[v] <= CW'(VC_FIFO_DEPTH);
      ptr_q              <= '0;
      tx_vc_target_q     <= '0;
      rx_vc_credit_gnt_q <= '0;
      tx_packet_q        <= '0;
      err_q              <= 1'b0;
    end else begin
      cred_q             <= cred_d;
      ptr_q              <= ptr_d;
      tx_vc_target_q     <= tx_vc_target_d;
      rx_vc_credit_gnt_q <= rx_vc_credit_gnt_d;
      tx_packet_q        <= tx_packet_d;
      err_q              <= err_d;
    end
  end

  assign nif.tx_vc_target     = tx_vc_target_q;
  assign nif.rx_vc_credit_gnt = rx_vc_credit_gnt_q;
  assign nif.tx_packet        = tx_packet_q;
  assign err                  = err_q;

`ifdef NOC_ROOT_ENDPOINT_STATS_EN
  logic [ROOT_EP_CNT_W-1:0] rx_count_q, rx_count_d;
  logic [ROOT_EP_CNT_W-1:0] tx_count_q, tx_count_d;

  always_comb begin
    rx_count_d = rx_count_q + ROOT_EP_CNT_W'(|fifo_push);
    tx_count_d = tx_count_q + ROOT_EP_CNT_W'(|gnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_noc_root_endpoint.sv
// tb/tb_noc_root_endpoint.sv - directed table and corner sequences for noc_root_endpoint
module tb_noc_root_endpoint;

  logic clk;
  logic rst;
  logic err;
`ifdef NOC_ROOT_ENDPOINT_STATS_EN
  logic [31:0] rx_count, tx_count;
`endif

  noc_root_endpoint_if #(.VC_W(2), .PKT_W(35)) nif ();

  noc_root_endpoint #(.N(4), .VC_W(2), .D_W(32), .VC_FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .nif (nif),
    .err (err)
`ifdef NOC_ROOT_ENDPOINT_STATS_EN
    ,
    .rx_count (rx_count),
    .tx_count (tx_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rx_vc;
    logic [34:0] rx_pkt;
    logic [1:0]  tx_cred;
    logic [1:0]  exp_vc;
    logic [34:0] exp_pkt;
  } vec_t;

  vec_t        vecs[$];
  logic [34:0] sent[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          idle_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [1:0] rv, input logic [34:0] rp, input logic [1:0] tc,
                     input logic [1:0] ev, input logic [34:0] ep);
    vec_t r;
    r.rx_vc = rv; r.rx_pkt = rp; r.tx_cred = tc; r.exp_vc = ev; r.exp_pkt = ep;
    vecs.push_back(r);
  endtask

  task automatic cyc(input logic [1:0] rv, input logic [34:0] rp, input logic [1:0] tc);
    @(negedge clk);
    nif.rx_vc_target     = rv;
    nif.rx_packet        = rp;
    nif.tx_vc_credit_gnt = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nif.rx_vc_target     = '0;
    nif.rx_packet        = '0;
    nif.tx_vc_credit_gnt = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic capture(input int cycles, input logic [1:0] rv, input logic [34:0] rp,
                         input logic [1:0] tc);
    for (int i = 0; i < cycles; i++) begin
      cyc(rv, rp, tc);
      if (nif.tx_vc_target != 2'b00) sent.push_back(nif.tx_packet);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Rows: inputs applied before an edge, outputs expected just after it.
    for (int i = 0; i < 4; i++) add(2'b00, '0, 2'b00, 2'b00, '0);
    add(2'b01, 35'h0_0000_00AB, 2'b00, 2'b00, '0);
    add(2'b00, '0, 2'b00, 2'b01, 35'h0_0000_00AB);
    add(2'b00, '0, 2'b01, 2'b00, '0);
    add(2'b10, 35'h4_1111_0001, 2'b00, 2'b00, '0);
    add(2'b10, 35'h2_2222_0002, 2'b00, 2'b10, 35'h4_1111_0001);
    add(2'b10, 35'h7_FFFF_FFFF, 2'b00, 2'b10, 35'h2_2222_0002);
    add(2'b00, '0, 2'b00, 2'b00, '0);
    add(2'b00, '0, 2'b00, 2'b00, '0);
    add(2'b00, '0, 2'b10, 2'b00, '0);
    add(2'b00, '0, 2'b00, 2'b10, 35'h7_FFFF_FFFF);
    add(2'b00, '0, 2'b10, 2'b00, '0);
    add(2'b00, '0, 2'b10, 2'b00, '0);
    add(2'b01, 35'h0_A000_0001, 2'b00, 2'b00, '0);
    add(2'b01, 35'h0_A000_0002, 2'b00, 2'b01, 35'h0_A000_0001);
    add(2'b10, 35'h1_B000_0001, 2'b00, 2'b01, 35'h0_A000_0002);
    add(2'b10, 35'h1_B000_0002, 2'b00, 2'b10, 35'h1_B000_0001);
    add(2'b01, 35'h0_A000_0003, 2'b00, 2'b10, 35'h1_B000_0002);
    add(2'b01, 35'h0_A000_0004, 2'b00, 2'b00, '0);
    add(2'b10, 35'h1_B000_0003, 2'b00, 2'b00, '0);
    add(2'b10, 35'h1_B000_0004, 2'b00, 2'b00, '0);
    add(2'b00, '0, 2'b11, 2'b00, '0);
    add(2'b01, 35'h0_A000_0005, 2'b01, 2'b01, 35'h0_A000_0003);
    add(2'b10, 35'h1_B000_0005, 2'b10, 2'b10, 35'h1_B000_0003);
    add(2'b01, 35'h0_A000_0006, 2'b01, 2'b01, 35'h0_A000_0004);
    add(2'b10, 35'h1_B000_0006, 2'b10, 2'b10, 35'h1_B000_0004);
    add(2'b00, '0, 2'b01, 2'b01, 35'h0_A000_0005);
    add(2'b00, '0, 2'b10, 2'b10, 35'h1_B000_0005);
    add(2'b00, '0, 2'b01, 2'b01, 35'h0_A000_0006);
    add(2'b00, '0, 2'b10, 2'b10, 35'h1_B000_0006);
    add(2'b00, '0, 2'b00, 2'b00, '0);

    // Reset with traffic present on the inputs.
    rst = 1'b1;
    nif.rx_vc_target     = 2'b01;
    nif.rx_packet        = 35'h0_DEAD_BEEF;
    nif.tx_vc_credit_gnt = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_tx_vc", nif.tx_vc_target, 2'b00);
      chk("rst_cred_gnt", nif.rx_vc_credit_gnt, 2'b00);
      chk("rst_tx_pkt", nif.tx_packet, '0);
      chk("rst_err", err, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    nif.rx_vc_target     = '0;
    nif.rx_packet        = '0;
    nif.tx_vc_credit_gnt = '0;

    foreach (vecs[k]) begin
      cyc(vecs[k].rx_vc, vecs[k].rx_pkt, vecs[k].tx_cred);
      chk($sformatf("row%0d_tx_vc", k), nif.tx_vc_target, vecs[k].exp_vc);
      chk($sformatf("row%0d_cred_gnt", k), nif.rx_vc_credit_gnt, vecs[k].exp_vc);
      if (vecs[k].exp_vc != 2'b00)
        chk($sformatf("row%0d_tx_pkt", k), nif.tx_packet, vecs[k].exp_pkt);
      chk($sformatf("row%0d_err", k), err, 1'b0);
    end

    // Overflow: third flit into a full VC0 with no credit is dropped.
    do_reset();
    cyc(2'b01, 35'h0_0000_0C01, 2'b00);
    cyc(2'b01, 35'h0_0000_0C02, 2'b00);
    chk("ovf_first_send", nif.tx_packet, 35'h0_0000_0C01);
    cyc(2'b01, 35'h0_0000_0D01, 2'b00);
    cyc(2'b01, 35'h0_0000_0D02, 2'b00);
    chk("ovf_stalled_tx", nif.tx_vc_target, 2'b00);
    chk("ovf_err_before", err, 1'b0);
    cyc(2'b01, 35'h0_0000_0D03, 2'b00);
    chk("ovf_err_set", err, 1'b1);
    sent.delete();
    capture(2, 2'b00, '0, 2'b01);
    capture(4, 2'b00, '0, 2'b00);
    chk("ovf_send_count", sent.size(), 2);
    chk("ovf_send0", (sent.size() > 0) ? sent[0] : '1, 35'h0_0000_0D01);
    chk("ovf_send1", (sent.size() > 1) ? sent[1] : '1, 35'h0_0000_0D02);

    // Credit overrun right after reset; counter must stay at its maximum.
    do_reset();
    cyc(2'b00, '0, 2'b01);
    chk("overrun_err", err, 1'b1);
    sent.delete();
    capture(1, 2'b01, 35'h0_0000_0E01, 2'b00);
    capture(1, 2'b01, 35'h0_0000_0E02, 2'b00);
    capture(1, 2'b01, 35'h0_0000_0E03, 2'b00);
    capture(4, 2'b00, '0, 2'b00);
    chk("overrun_send_count", sent.size(), 2);
    chk("overrun_send0", (sent.size() > 0) ? sent[0] : '1, 35'h0_0000_0E01);
    chk("overrun_send1", (sent.size() > 1) ? sent[1] : '1, 35'h0_0000_0E02);

    // Mid-operation reset with two flits buffered on VC0 and a send on VC1 in flight.
    do_reset();
    cyc(2'b01, 35'h0_0000_0F01, 2'b00);
    cyc(2'b01, 35'h0_0000_0F02, 2'b00);
    cyc(2'b01, 35'h0_0000_0F03, 2'b00);
    cyc(2'b01, 35'h0_0000_0F04, 2'b00);
    chk("midrst_stall", nif.tx_vc_target, 2'b00);
    cyc(2'b10, 35'h1_0000_0F05, 2'b00);
    cyc(2'b00, '0, 2'b00);
    chk("midrst_pre_tx", nif.tx_vc_target, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx_vc", nif.tx_vc_target, 2'b00);
    chk("midrst_cred_gnt", nif.rx_vc_credit_gnt, 2'b00);
    chk("midrst_tx_pkt", nif.tx_packet, '0);
    chk("midrst_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, '0, 2'b00);
      if (nif.tx_vc_target != 2'b00 || nif.rx_vc_credit_gnt != 2'b00) idle_bad++;
    end
    chk("midrst_no_stale", idle_bad, 0);
    cyc(2'b01, 35'h0_0000_0A01, 2'b00);
    cyc(2'b01, 35'h0_0000_0A02, 2'b00);
    chk("fresh_tx0_vc", nif.tx_vc_target, 2'b01);
    chk("fresh_tx0_pkt", nif.tx_packet, 35'h0_0000_0A01);
    cyc(2'b00, '0, 2'b00);
    chk("fresh_tx1_vc", nif.tx_vc_target, 2'b01);
    chk("fresh_tx1_pkt", nif.tx_packet, 35'h0_0000_0A02);
    chk("fresh_cred_gnt", nif.rx_vc_credit_gnt, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
